overload_controller: RTL

//  Sequences the CAN interframe phase and schedules the overload_frame and error-frame generators.
//  - Tracks frame, intermission, idle, overload and error phases.
//  - Detects the two overload conditions, limits consecutive overloads and gives error frames priority.
//  - Selects which generator drives the transmit bit.
//  - Sits between bit-timing/rx logic and the overload_frame and error-frame blocks.

---
 rtl/can_pkg.sv | 18 +
 rtl/overload_controller_if.sv | 38 +++
 rtl/overload_controller_intermission_timer.sv | 26 ++
 rtl/overload_controller.sv | 137 +++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN interframe/overload controller.
package can_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_FRAME        = 3'd1,
    ST_INTERMISSION = 3'd2,
    ST_OVERLOAD     = 3'd3,
    ST_ERROR        = 3'd4
  } ctrl_state_t;

  localparam int INTERMISSION_BITS_C = 3;
  localparam int MAX_OVERLOADS_C     = 2;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/overload_controller_if.sv
// Bit-level and generator handshake signals around the overload controller.
interface overload_controller_if;
  logic       enable;
  logic       sample_point;
  logic       rx_bit;
  logic       rx_not_ready;
  logic       eof_done;
  logic       error_request;
  logic       error_frame_complete;
  logic       overload_frame_complete;
  logic       overload_flag_bit;
  logic       error_flag_bit;
  logic       tx_data_bit;
  logic       overload_enable;
  logic       overload_condition_1;
  logic       overload_condition_2;
  logic [1:0] overload_count;
  logic       error_enable;
  logic       tx_bit;
  logic       bus_idle;
  logic       sof_detect;

  modport master (
    input  enable, sample_point, rx_bit, rx_not_ready, eof_done, error_request,
           error_frame_complete, overload_frame_complete, overload_flag_bit,
           error_flag_bit, tx_data_bit,
    output overload_enable, overload_condition_1, overload_condition_2,
           overload_count, error_enable, tx_bit, bus_idle, sof_detect
  );

  modport slave (
    output enable, sample_point, rx_bit, rx_not_ready, eof_done, error_request,
           error_frame_complete, overload_frame_complete, overload_flag_bit,
           error_flag_bit, tx_data_bit,
    input  overload_enable, overload_condition_1, overload_condition_2,
           overload_count, error_enable, tx_bit, bus_idle, sof_detect
  );
endinterface

// File: rtl/overload_controller_intermission_timer.sv
// Intermission bit counter: held at zero while cleared, advances on sample strobes.
module intermission_timer #(
  parameter int BITS = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic incr,
  output logic is_last_bit
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && !is_last_bit) begin
      count <= count + 1'b1;
    end
  end

  assign is_last_bit = (count == CW'(BITS - 1));
endmodule

// File: rtl/overload_controller.sv
// CAN interframe sequencer: tracks frame/intermission phases and schedules overload and error frames.
//
//  state           | meaning
//  ST_IDLE         | bus idle, waiting for a dominant SOF bit
//  ST_FRAME        | data/remote frame in progress until end-of-frame
//  ST_INTERMISSION | counting intermission bits, watching for overload conditions
//  ST_OVERLOAD     | overload frame generator active
//  ST_ERROR        | error frame generator active
module overload_controller
  import can_pkg::*;
#(
  parameter int INTERMISSION_BITS = INTERMISSION_BITS_C,
  parameter int MAX_OVERLOADS     = MAX_OVERLOADS_C
) (
  input logic                   clock,
  input logic                   reset_n,
  overload_controller_if.master bus
);
  ctrl_state_t state;
  logic        pend_c1;
  logic        is_last_bit;
  logic        below_max;

  intermission_timer #(.BITS(INTERMISSION_BITS)) u_timer (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (!bus.enable || (state != ST_INTERMISSION)),
    .incr        (bus.sample_point),
    .is_last_bit (is_last_bit)
  );

  assign below_max = (bus.overload_count < 2'(MAX_OVERLOADS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= ST_IDLE;
      pend_c1                  <= 1'b0;
      bus.overload_count       <= 2'd0;
      bus.overload_enable      <= 1'b0;
      bus.overload_condition_1 <= 1'b0;
      bus.overload_condition_2 <= 1'b0;
      bus.error_enable         <= 1'b0;
      bus.bus_idle             <= 1'b1;
      bus.sof_detect           <= 1'b0;
    end else if (!bus.enable) begin
      state                    <= ST_IDLE;
      pend_c1                  <= 1'b0;
      bus.overload_count       <= 2'd0;
      bus.overload_enable      <= 1'b0;
      bus.overload_condition_1 <= 1'b0;
      bus.overload_condition_2 <= 1'b0;
      bus.error_enable         <= 1'b0;
      bus.bus_idle             <= 1'b1;
      bus.sof_detect           <= 1'b0;
    end else begin
      bus.overload_condition_1 <= 1'b0;
      bus.overload_condition_2 <= 1'b0;
      bus.sof_detect           <= 1'b0;
      // Error request pre-empts every other event, including completion pulses.
      if (bus.error_request && (state != ST_ERROR)) begin
        state               <= ST_ERROR;
        bus.overload_enable <= 1'b0;
        bus.error_enable    <= 1'b1;
        bus.bus_idle        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.sample_point && (bus.rx_bit == DOMINANT)) begin
              state              <= ST_FRAME;
              bus.sof_detect     <= 1'b1;
              bus.overload_count <= 2'd0;
              bus.bus_idle       <= 1'b0;
            end
          end
          ST_FRAME: begin
            if (bus.eof_done) begin
              state   <= ST_INTERMISSION;
              pend_c1 <= bus.rx_not_ready;
            end
          end
          ST_INTERMISSION: begin
            if (bus.sample_point) begin
              if (pend_c1 && below_max) begin
                state                    <= ST_OVERLOAD;
                bus.overload_enable      <= 1'b1;
                bus.overload_condition_1 <= 1'b1;
              end else if ((bus.rx_bit == DOMINANT) && !is_last_bit && below_max) begin
                state                    <= ST_OVERLOAD;
                bus.overload_enable      <= 1'b1;
                bus.overload_condition_2 <= 1'b1;
              end else if (is_last_bit && (bus.rx_bit == DOMINANT)) begin
                state              <= ST_FRAME;
                bus.sof_detect     <= 1'b1;
                bus.overload_count <= 2'd0;
              end else if (is_last_bit) begin
                state              <= ST_IDLE;
                bus.overload_count <= 2'd0;
                bus.bus_idle       <= 1'b1;
              end
            end
          end
          ST_OVERLOAD: begin
            if (bus.overload_frame_complete) begin
              state               <= ST_INTERMISSION;
              pend_c1             <= 1'b0;
              bus.overload_enable <= 1'b0;
              if (bus.overload_count != 2'd3) begin
                bus.overload_count <= bus.overload_count + 2'd1;
              end
            end
          end
          ST_ERROR: begin
            if (bus.error_frame_complete) begin
              state              <= ST_INTERMISSION;
              pend_c1            <= 1'b0;
              bus.error_enable   <= 1'b0;
              bus.overload_count <= 2'd0;
            end
          end
          default: begin
            state        <= ST_IDLE;
            bus.bus_idle <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    case (state)
      ST_ERROR:    bus.tx_bit = bus.error_flag_bit;
      ST_OVERLOAD: bus.tx_bit = bus.overload_flag_bit;
      ST_FRAME:    bus.tx_bit = bus.tx_data_bit;
      default:     bus.tx_bit = RECESSIVE;
    endcase
  end
endmodule
